// File: rtl/param_counter.sv
// Up/down counter over the range 0..limit with wrap or saturate at the boundaries.
// Terminal-count pulse and sticky boundary flag are registered alongside count.
module param_counter #(
   parameter int unsigned    WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             at_top, at_bottom;

   // Counts above limit (after limit is lowered) still count as the top boundary.
   assign at_top    = (count_q >= limit);
   assign at_bottom = (count_q == '0);

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
      end else if (en) begin
         if (up) begin
            if (at_top) begin
               count_d = mode ? limit : '0;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (at_bottom) begin
               count_d = mode ? '0 : limit;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
      // A boundary event on the same edge as a clear keeps the flag set.
      if (tc_d) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_VAL;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: directed vector table, long directed
// sequences, and randomized stimulus against an integer reference model.
module tb_param_counter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned MAXV  = (1 << WIDTH) - 1;

   logic             clk;
   logic             reset, en, up, mode, load, clr_ovf;
   logic [WIDTH-1:0] load_val, limit;
   logic [WIDTH-1:0] count;
   logic             tc, ovf;

   int n_tests;
   int n_fail;

   param_counter #(
      .WIDTH    (WIDTH),
      .RESET_VAL(8'd0)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .up      (up),
      .mode    (mode),
      .load    (load),
      .load_val(load_val),
      .limit   (limit),
      .clr_ovf (clr_ovf),
      .count   (count),
      .tc      (tc),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, up, mode, ld;
      logic [7:0] ldv, lim;
      logic       clr;
      logic [7:0] e_count;
      logic       e_tc, e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic u, input logic m,
                      input logic l, input int lv, input int lm, input logic c,
                      input int ec, input logic et, input logic eo);
      vec_t v;
      v.rst = r; v.en = e; v.up = u; v.mode = m; v.ld = l;
      v.ldv = 8'(lv); v.lim = 8'(lm); v.clr = c;
      v.e_count = 8'(ec); v.e_tc = et; v.e_ovf = eo;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic u, input logic m,
                        input logic l, input logic [7:0] lv, input logic [7:0] lm,
                        input logic c);
      reset = r; en = e; up = u; mode = m; load = l;
      load_val = lv; limit = lm; clr_ovf = c;
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model state, plain integers.
   int m_count;
   bit m_tc, m_ovf;

   task automatic model_step(input bit r, input bit e, input bit u, input bit m,
                             input bit l, input int lv, input int lm, input bit c);
      bit boundary;
      boundary = 0;
      if (r) begin
         m_count = 0; m_tc = 0; m_ovf = 0;
         return;
      end
      if (l) begin
         m_count = (lv < lm) ? lv : lm;
      end else if (e && u) begin
         if (m_count < lm) m_count = m_count + 1;
         else begin
            boundary = 1;
            m_count  = m ? lm : 0;
         end
      end else if (e) begin
         if (m_count > 0) m_count = m_count - 1;
         else begin
            boundary = 1;
            m_count  = m ? 0 : lm;
         end
      end
      m_tc = boundary;
      if (boundary) m_ovf = 1;
      else if (c) m_ovf = 0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      drive(1, 0, 0, 0, 0, 8'd0, 8'd0, 0);

      // rst en up md ld ldv lim clr -> count tc ovf
      add(1, 0, 0, 0, 0,   0,   0, 0,   0, 0, 0);
      add(0, 0, 0, 0, 1,   2,   9, 0,   2, 0, 0);
      add(0, 1, 0, 0, 0,   0,   9, 0,   1, 0, 0);
      add(0, 1, 0, 0, 0,   0,   9, 0,   0, 0, 0);
      add(0, 1, 0, 0, 0,   0,   9, 0,   9, 1, 1);
      add(0, 1, 0, 0, 0,   0,   9, 0,   8, 0, 1);
      add(0, 1, 1, 0, 1, 200, 100, 0, 100, 0, 1);
      add(0, 1, 1, 0, 0,   0,  50, 0,   0, 1, 1);
      add(0, 0, 0, 0, 0,   0,  50, 1,   0, 0, 0);
      add(0, 1, 0, 1, 0,   0,  50, 0,   0, 1, 1);
      add(0, 1, 0, 1, 0,   0,  50, 1,   0, 1, 1);
      add(0, 0, 0, 0, 0,   0,  50, 1,   0, 0, 0);
      add(0, 0, 0, 0, 1, 100, 100, 0, 100, 0, 0);
      add(0, 1, 1, 0, 0,   0, 100, 0,   0, 1, 1);
      add(0, 0, 0, 0, 1,  37, 100, 0,  37, 0, 1);
      add(1, 1, 1, 0, 1,  99, 100, 0,   0, 0, 0);
      add(0, 1, 1, 0, 0,   0,   0, 0,   0, 1, 1);
      add(0, 1, 0, 1, 0,   0,   0, 0,   0, 1, 1);
      add(0, 0, 0, 0, 1,  30, 200, 0,  30, 0, 1);
      add(0, 0, 0, 0, 0,   0,  10, 0,  30, 0, 1);
      add(0, 1, 1, 1, 0,   0,  10, 0,  10, 1, 1);
      add(0, 1, 0, 0, 0,   0,  10, 0,   9, 0, 1);
      add(0, 0, 0, 0, 1,  40, 255, 1,  40, 0, 0);
      add(0, 1, 0, 0, 0,   0,  10, 0,  39, 0, 0);
      add(0, 0, 0, 0, 1, 255, 255, 0, 255, 0, 0);
      add(0, 1, 1, 1, 0,   0, 255, 0, 255, 1, 1);
      add(0, 1, 1, 0, 0,   0, 255, 0,   0, 1, 1);
      add(0, 1, 1, 0, 0,   0, 255, 0,   1, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].mode, vecs[i].ld,
               vecs[i].ldv, vecs[i].lim, vecs[i].clr);
         tick();
         check($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].e_count));
         check($sformatf("vec%0d.tc", i), int'(tc), int'(vecs[i].e_tc));
         check($sformatf("vec%0d.ovf", i), int'(ovf), int'(vecs[i].e_ovf));
      end

      // Full-range wrap: 256 increments from 0 with limit at the maximum.
      drive(1, 0, 0, 0, 0, 8'd0, 8'd255, 0);
      tick();
      check("wrap.reset_count", int'(count), 0);
      drive(0, 1, 1, 0, 0, 8'd0, 8'd255, 0);
      for (int k = 1; k <= 256; k++) begin
         tick();
         check($sformatf("wrap%0d.count", k), int'(count), k % 256);
         check($sformatf("wrap%0d.tc", k), int'(tc), (k == 256) ? 1 : 0);
      end
      check("wrap.ovf", int'(ovf), 1);

      // Saturating up-count to 9: tc stays high while pinned at the limit.
      drive(1, 0, 0, 0, 0, 8'd0, 8'd9, 0);
      tick();
      drive(0, 1, 1, 1, 0, 8'd0, 8'd9, 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         check($sformatf("sat%0d.count", k), int'(count), (k < 9) ? k : 9);
         check($sformatf("sat%0d.tc", k), int'(tc), (k >= 10) ? 1 : 0);
      end

      // Randomized stimulus against the reference model.
      drive(1, 0, 0, 0, 0, 8'd0, 8'd0, 0);
      tick();
      model_step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3000; k++) begin
         bit r, e, u, m, l, c;
         int lv, lm;
         r  = ($urandom_range(0, 63) == 0);
         l  = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         u  = $urandom_range(0, 1) != 0;
         m  = $urandom_range(0, 1) != 0;
         c  = ($urandom_range(0, 7) == 0);
         lv = $urandom_range(0, MAXV);
         case ($urandom_range(0, 3))
            0:       lm = 0;
            1:       lm = MAXV;
            2:       lm = $urandom_range(0, 15);
            default: lm = $urandom_range(0, MAXV);
         endcase
         drive(r, e, u, m, l, 8'(lv), 8'(lm), c);
         model_step(r, e, u, m, l, lv, lm, c);
         tick();
         check($sformatf("rnd%0d.count", k), int'(count), m_count);
         check($sformatf("rnd%0d.tc", k), int'(tc), int'(m_tc));
         check($sformatf("rnd%0d.ovf", k), int'(ovf), int'(m_ovf));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
